pp_gen_stage: RTL and testbench

//  Registered partial-product generator feeding the Wallace reduction tree.
//  - Accepts operand pairs A/B over a valid/ready handshake.
//  - Forms the WIDTH x WIDTH AND matrix, one row per multiplier bit.
//  - Presents the matrix to the tree through a 2-entry skid buffer, so the

---
 rtl/pp_gen_stage.sv | 77 +++++++
 tb/tb_pp_gen_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pp_gen_stage.sv
// Registered partial-product generator with a 2-entry skid buffer toward the Wallace tree.
// Define SIGNED_PP_EN to build Baugh-Wooley signed rows instead of the plain unsigned AND matrix.
module pp_gen_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a_in,
  input  logic [WIDTH-1:0]       b_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WIDTH-1:0] pp_out,
  output logic [CNT_W-1:0]       op_cnt
);

  localparam int PPW = WIDTH * WIDTH;

  logic [PPW-1:0] pp_next;
  logic [PPW-1:0] main_d, skid_d;
  logic           main_v, skid_v;
  logic           acc, drain;

  // One row per multiplier bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    logic [WIDTH-1:0] row;
    assign row = a_in & {WIDTH{b_in[i]}};
`ifdef SIGNED_PP_EN
    // Baugh-Wooley: the tree adds the correction constant.
    if (i < WIDTH - 1) begin : g_mid
      assign pp_next[i*WIDTH +: WIDTH] = row ^ {1'b1, {(WIDTH-1){1'b0}}};
    end else begin : g_top
      assign pp_next[i*WIDTH +: WIDTH] = row ^ {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    assign pp_next[i*WIDTH +: WIDTH] = row;
`endif
  end

  // Ready depends only on registered state, so out_ready never reaches in_ready.
  assign in_ready  = !skid_v && !rst;
  assign acc       = in_valid && in_ready;
  assign drain     = main_v && out_ready;
  assign out_valid = main_v;
  assign pp_out    = main_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
      op_cnt <= '0;
    end else begin
      if (!main_v || drain) begin
        // Skid holds the older entry and must go first; no accept can coincide.
        if (skid_v) begin
          main_d <= skid_d;
          main_v <= 1'b1;
          skid_v <= 1'b0;
        end else if (acc) begin
          main_d <= pp_next;
          main_v <= 1'b1;
        end else begin
          main_v <= 1'b0;
        end
      end else if (acc) begin
        skid_d <= pp_next;
        skid_v <= 1'b1;
      end
      if (drain) op_cnt <= op_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pp_gen_stage.sv
// Directed bench for pp_gen_stage at WIDTH=4: reset, single op, backpressure, streaming, mid-stall reset.
module tb_pp_gen_stage;
  localparam int W   = 4;
  localparam int CW  = 16;
  localparam int PPW = W * W;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]   a_in, b_in;
  logic [PPW-1:0] pp_out;
  logic [CW-1:0]  op_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pp_gen_stage #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pp_out(pp_out), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-level reference: product bit a[j]&b[i], with Baugh-Wooley inversions in the signed build.
  function automatic logic [PPW-1:0] pp_model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PPW-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++) begin
        logic bitv;
        bitv = a[j] & b[i];
`ifdef SIGNED_PP_EN
        if ((i == W-1) != (j == W-1)) bitv = ~bitv;
`endif
        r[i*W + j] = bitv;
      end
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  logic [PPW-1:0] exp_q[$];
  logic [PPW-1:0] px, py, pz;
  logic [CW-1:0]  cnt0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;

    // Reset
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_cnt", op_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_pp_out", pp_out, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // Single op, hand-computed matrix
    a_in = 4'hB; b_in = 4'h5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_out_valid", out_valid, 1);
`ifdef SIGNED_PP_EN
    chk("single_pp_signed", pp_out, 16'h7383);
`else
    chk("single_pp_unsigned", pp_out, 16'h0B0B);
`endif
    chk("single_cnt_before_drain", op_cnt, 0);
    tick();
    chk("single_cnt", op_cnt, 1);
    chk("single_drained", out_valid, 0);

    // Backpressure: X, Y, Z with the tree stalled
    px = pp_model(4'h3, 4'h7); py = pp_model(4'hC, 4'h9); pz = pp_model(4'hF, 4'hE);
    out_ready = 1'b0;
    a_in = 4'h3; b_in = 4'h7; in_valid = 1'b1;
    tick();
    chk("bp_x_main", pp_out, px);
    chk("bp_ready_after_x", in_ready, 1);
    a_in = 4'hC; b_in = 4'h9;
    tick();
    chk("bp_ready_after_y", in_ready, 0);
    chk("bp_hold_x", pp_out, px);
    a_in = 4'hF; b_in = 4'hE;
    tick();
    chk("bp_z_held_ready", in_ready, 0);
    chk("bp_stable_pp", pp_out, px);
    chk("bp_stable_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_y_out", pp_out, py);
    chk("bp_ready_back", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_z_out", pp_out, pz);
    chk("bp_z_valid", out_valid, 1);
    tick();
    chk("bp_empty", out_valid, 0);
    chk("bp_cnt", op_cnt, 4);

    // Streaming: 100 random ops, one per clock
    cnt0 = op_cnt;
    begin
      int sent = 0, got = 0, cyc = 0;
      while ((sent < 100 || exp_q.size() != 0) && cyc < 400) begin
        if (out_valid) begin
          if (exp_q.size() == 0) chk("stream_unexpected", 1, 0);
          else chk("stream_data", pp_out, exp_q.pop_front());
          got++;
        end else if (sent > 0 && sent < 100) begin
          chk("stream_bubble", out_valid, 1);
        end
        if (sent < 100) begin
          a_in = W'($urandom); b_in = W'($urandom); in_valid = 1'b1;
          chk("stream_in_ready", in_ready, 1);
          if (in_ready) begin exp_q.push_back(pp_model(a_in, b_in)); sent++; end
        end else in_valid = 1'b0;
        tick();
        cyc++;
      end
      if (cyc >= 400) chk("stream_timeout", cyc, 0);
      chk("stream_count", got, 100);
      chk("stream_cycles", cyc, 101);
    end
    in_valid = 1'b0;
    chk("stream_op_cnt", op_cnt, cnt0 + 16'd100);

    // Reset with main and skid both full
    out_ready = 1'b0;
    a_in = 4'h6; b_in = 4'hA; in_valid = 1'b1;
    tick();
    a_in = 4'h9; b_in = 4'h3;
    tick();
    in_valid = 1'b0;
    chk("mid_full_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", op_cnt, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_pp", pp_out, 0);
    rst = 1'b0; out_ready = 1'b1;
    begin
      int stale = 0;
      repeat (4) begin tick(); if (out_valid) stale++; end
      chk("mid_no_stale", stale, 0);
    end
    chk("mid_cnt_after", op_cnt, 0);
    chk("mid_ready_after", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
